mem_boot_loader: RTL
====================

# mem_boot_loader

Serial boot controller for main-memory port A. After reset it owns the memory write port and holds the CPU in reset. It receives a framed program image over the 16-bit serial word interface, writes the image into main memory from address 0, and verifies a checksum. On success it hands port A to the CPU through a zero-latency mux and releases CPU reset; on failure it keeps the CPU in reset.

## Interface
- ADDR_W, 14: main-memory word-address width.
- MAX_WORDS, 16384: largest accepted image length, in words.
- MAGIC, 16'hB007: frame start word.
- Clock  in  1  system clock; every register updates on posedge.
- Reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- serialValid  in  1  one-cycle strobe; serialRead holds a new word.
- serialRead  in  16  received serial word.
- cpu_mem_addr  in  16  CPU memory address.
- cpu_mem_write  in  1  CPU write enable.
- cpu_data_in  in  16  CPU write data.
- mem_addr  out  ADDR_W  port-A address to memory.
- mem_write  out  1  port-A write enable.
- mem_data  out  16  port-A write data.
- cpu_reset  out  1  reset to the CPU; high until a successful boot.
- boot_done  out  1  high in RUN.
- boot_error  out  1  high in ERROR.
- words_loaded  out  ADDR_W+1  count of image words written in the current frame.

## Operation
- Frame format: MAGIC, LEN, LEN data words, CHK. CHK is the 16-bit wrap-around sum of the data words.
- FSM states: IDLE, LEN, LOAD, CHECK, RUN, ERROR.
- IDLE: a serial word equal to MAGIC -> LEN. Any other word is ignored.
- LEN:
  - Latch LEN and clear words_loaded, the index and the sum.
  - LEN==0 -> CHECK.
  - LEN>MAX_WORDS -> ERROR.
  - Otherwise -> LOAD.
- LOAD: on each word:
  - Write it to address index.
  - Add it to the sum, mod 2^16.
  - Increment index and words_loaded.
  - When words_loaded reaches LEN -> CHECK.
  - A MAGIC value inside LOAD is data, not a restart.
- CHECK: the next word is compared with the sum. Equal -> RUN; unequal -> ERROR.
- RUN:
  - mem_addr = cpu_mem_addr[ADDR_W-1:0], mem_write = cpu_mem_write, mem_data = cpu_data_in.
  - All three are combinational pass-through.
  - Serial words are ignored. Only Reset leaves RUN.
- ERROR:
  - cpu_reset stays 1 and memory is not written.
  - A MAGIC word -> LEN, which restarts the frame. Other words are ignored.
- In every state except RUN, port A is driven only by the loader. CPU address, write and data inputs are ignored.
- mem_write from the loader is asserted only for LOAD data words. It is never asserted for MAGIC, LEN or CHK.

## Timing
- Reset values (registered outputs, or the mux in IDLE):
  - state=IDLE, cpu_reset=1, boot_done=0, boot_error=0.
  - mem_write=0, mem_addr=0, mem_data=0, words_loaded=0.
- Loader write latency: serialValid at cycle N -> mem_write=1 with registered address/data during cycle N+1. mem_write is high for exactly one cycle.
- Back-to-back serialValid on consecutive cycles is supported: one write per cycle, no words dropped.
- CHK accepted at cycle N -> at cycle N+1, state=RUN, boot_done=1 and cpu_reset=0.
- Mismatch at cycle N -> at cycle N+1, boot_error=1.
- RUN mux: zero latency.
- Index wrap: this cannot occur, because LEN is bounded by MAX_WORDS (2^ADDR_W).
- Reset at any cycle: the next state is IDLE. Any pending loader write is cancelled. Memory contents already written are left as they are.
- serialValid in the same cycle as Reset is dropped.

## Structure
- The shared package holds:
  - the state enum (IDLE, LEN, LOAD, CHECK, RUN, ERROR);
  - the MAGIC constant;
  - the frame-field order;
  - so that the host-side loader tool and the bench use the same definitions.
- One natural sub-module, boot_port_mux: a combinational 2:1 port-A mux (loader vs CPU) selected by boot_done. It has no other logic.

## Test plan
- MAGIC, LEN=3, 16'h1111, 16'h2222, 16'h3333, CHK=16'h6666 -> three writes to addresses 0,1,2 with that data. One cycle after CHK: boot_done=1, cpu_reset=0.
- Same frame with CHK=16'h6667 -> boot_error=1, cpu_reset=1. A following valid frame starting with MAGIC -> RUN.
- MAGIC, LEN=0, CHK=0 -> RUN with zero writes. LEN=16385 -> ERROR immediately.
- Words 16'h1234 and 16'hFFFF before MAGIC -> no writes, state stays IDLE.
- Data 16'hFFFF, 16'h0002 -> sum wraps to 16'h0001. CHK=1 is accepted. In RUN, cpu_mem_addr=16'h0005 with write=1 appears on port A in the same cycle.
- Reset asserted after 2 of 4 LOAD words -> IDLE, words_loaded=0, cpu_reset=1, no further writes. A full reload then succeeds.

Source files
------------

// File: rtl/mem_boot_loader_pkg.sv
// Shared boot-loader definitions: FSM states, frame start word and frame field order.
// The host-side image tool and the bench build frames from the same constants.
package mem_boot_loader_pkg;

  localparam logic [15:0] MAGIC = 16'hB007;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } boot_state_e;

  // Order of fields on the wire: MAGIC, LEN, LEN data words, CHK.
  typedef enum logic [1:0] {
    FIELD_MAGIC,
    FIELD_LEN,
    FIELD_DATA,
    FIELD_CHK
  } frame_field_e;

endpackage

// File: rtl/mem_boot_loader_boot_port_mux.sv
// Port-A 2:1 mux: the loader owns memory until boot completes, then the CPU does.
module mem_boot_loader_boot_port_mux #(
  parameter int ADDR_W = 14
) (
  input  logic              sel_cpu,
  input  logic [ADDR_W-1:0] loader_addr,
  input  logic              loader_write,
  input  logic [15:0]       loader_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [15:0]       cpu_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [15:0]       mem_data
);

  assign mem_addr  = sel_cpu ? cpu_addr  : loader_addr;
  assign mem_write = sel_cpu ? cpu_write : loader_write;
  assign mem_data  = sel_cpu ? cpu_data  : loader_data;

endmodule

// File: rtl/mem_boot_loader.sv
// Serial boot controller: receives MAGIC/LEN/data/CHK frames, writes the image from
// address 0, verifies the checksum and then hands memory port A to the CPU.
module mem_boot_loader
  import mem_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 16384
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              serialValid,
  input  logic [15:0]       serialRead,
  input  logic [15:0]       cpu_mem_addr,
  input  logic              cpu_mem_write,
  input  logic [15:0]       cpu_data_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [15:0]       mem_data,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0]       MAX_LEN = 17'(MAX_WORDS);
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  boot_state_e       state_reg, state_next;
  logic [ADDR_W:0]   len_reg, len_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [ADDR_W-1:0] index_reg, index_next;
  logic [15:0]       sum_reg, sum_next;
  logic [ADDR_W-1:0] ld_addr_reg, ld_addr_next;
  logic [15:0]       ld_data_reg, ld_data_next;
  logic              ld_write_reg, ld_write_next;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Reset also kills a write registered on the same edge, so a frame cut short never lands.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      len_reg      <= '0;
      count_reg    <= '0;
      index_reg    <= '0;
      sum_reg      <= '0;
      ld_addr_reg  <= '0;
      ld_data_reg  <= '0;
      ld_write_reg <= 1'b0;
    end else begin
      len_reg      <= len_next;
      count_reg    <= count_next;
      index_reg    <= index_next;
      sum_reg      <= sum_next;
      ld_addr_reg  <= ld_addr_next;
      ld_data_reg  <= ld_data_next;
      ld_write_reg <= ld_write_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    count_next    = count_reg;
    index_next    = index_reg;
    sum_next      = sum_reg;
    ld_addr_next  = ld_addr_reg;
    ld_data_next  = ld_data_reg;
    ld_write_next = 1'b0;
    if (serialValid) begin
      case (state_reg)
        IDLE, ERROR: begin
          if (serialRead == MAGIC) state_next = LEN;
        end
        LEN: begin
          len_next   = serialRead[ADDR_W:0];
          count_next = '0;
          index_next = '0;
          sum_next   = '0;
          if (serialRead == 16'd0)               state_next = CHECK;
          else if ({1'b0, serialRead} > MAX_LEN) state_next = ERROR;
          else                                   state_next = LOAD;
        end
        LOAD: begin
          // Every word here is payload, including one that happens to equal MAGIC.
          ld_write_next = 1'b1;
          ld_addr_next  = index_reg;
          ld_data_next  = serialRead;
          sum_next      = sum_reg + serialRead;
          index_next    = index_reg + IDX_ONE;
          count_next    = count_reg + CNT_ONE;
          if (count_reg + CNT_ONE == len_reg) state_next = CHECK;
        end
        CHECK: begin
          state_next = (serialRead == sum_reg) ? RUN : ERROR;
        end
        RUN: begin
          state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign boot_done    = (state_reg == RUN);
  assign boot_error   = (state_reg == ERROR);
  assign cpu_reset    = ~boot_done;
  assign words_loaded = count_reg;

  generate
    if (ADDR_W < 16) begin : g_addr_trunc
      logic unused_cpu_addr_hi;
      assign unused_cpu_addr_hi = ^cpu_mem_addr[15:ADDR_W];
    end
  endgenerate

  mem_boot_loader_boot_port_mux #(
    .ADDR_W(ADDR_W)
  ) u_port_mux (
    .sel_cpu     (boot_done),
    .loader_addr (ld_addr_reg),
    .loader_write(ld_write_reg),
    .loader_data (ld_data_reg),
    .cpu_addr    (cpu_mem_addr[ADDR_W-1:0]),
    .cpu_write   (cpu_mem_write),
    .cpu_data    (cpu_data_in),
    .mem_addr    (mem_addr),
    .mem_write   (mem_write),
    .mem_data    (mem_data)
  );

endmodule
